// File: rtl/nibble_serial_add16.sv
// 16-bit adder that time-multiplexes one 4-bit ripple slice, LS nibble first.
// Latency: accept edge T0, nibbles written T1..T4, out_valid in the cycle after T4.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.

module bit4Ad (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end
endmodule

module nibble_serial_add16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] sum,
    output logic        cout,
    output logic        ov
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] a_q, b_q;
    logic        carry_q;
    logic [1:0]  cnt;
    logic [3:0]  a_nib, b_nib, s_nib;
    logic        c_nib;
    logic        accept;
    logic        last_nib;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last_nib  = (cnt == 2'd3);

    // Operand mux selects the nibble addressed by the counter
    assign a_nib = a_q[{cnt, 2'b00} +: 4];
    assign b_nib = b_q[{cnt, 2'b00} +: 4];

    bit4Ad u_add (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .s    (s_nib),
        .cout (c_nib)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last_nib) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ov      <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt     <= '0;
        end else if (state == RUN) begin
            sum[{cnt, 2'b00} +: 4] <= s_nib;
            carry_q                <= c_nib;
            cnt                    <= cnt + 2'd1;
            if (last_nib) begin
                // Overflow uses the freshly produced top bit, not the stale sum register
                cout <= c_nib;
                ov   <= (a_q[15] == b_q[15]) && (s_nib[3] != a_q[15]);
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_add16.sv
// Bench for nibble_serial_add16: directed vector table, multi-cycle corner
// sequences and randomized operations against an arithmetic reference model.

module tb_nibble_serial_add16;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ov;

    int total;
    int bad;

    nibble_serial_add16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ov        (ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vcin;
        logic [15:0] es;
        logic        ec;
        logic        eo;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    // Reference: plain 17-bit addition and the signed-overflow rule
    task automatic model(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                         output logic [15:0] s, output logic c, output logic o);
        logic [16:0] full;
        full = {1'b0, ta} + {1'b0, tb} + {16'h0, tcin};
        s = full[15:0];
        c = full[16];
        o = (ta[15] == tb[15]) && (s[15] != ta[15]);
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                          input int hold, input bit pulse,
                          input logic [15:0] es, input logic ec, input logic eo);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        a = ta; b = tb; cin = tcin; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        chk("in_ready_fall", {31'd0, in_ready}, 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            in_valid = (pulse && n == 1);
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("latency", n, 32'd4);
        chk("result", {14'd0, sum, cout, ov}, {14'd0, es, ec, eo});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_result", {14'd0, sum, cout, ov}, {14'd0, es, ec, eo});
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("consumed", {31'd0, out_valid}, 32'd0);
        chk("in_ready_rise", {31'd0, in_ready}, 32'd1);
        chk("result_kept", {14'd0, sum, cout, ov}, {14'd0, es, ec, eo});
    endtask

    int          acc_n, res_n;
    int          acc_t[2];
    logic [17:0] res[2];
    bit          accepting;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rs, ra, rb;
        logic        rc, ro, rcin;

        total = 0; bad = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;

        vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[7] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_outputs", {14'd0, sum, cout, ov}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, 0, 1'b0,
                   vecs[i].es, vecs[i].ec, vecs[i].eo);

        // Stalled consumer plus a stray in_valid pulse during RUN
        run_op(16'h1234, 16'h4321, 1'b1, 3, 1'b1, 16'h5556, 1'b0, 1'b0);

        // Back-to-back with out_ready tied high; operands change right after accept
        acc_n = 0; res_n = 0; acc_t[0] = 0; acc_t[1] = 0; res[0] = '0; res[1] = '0;
        a = 16'h8000; b = 16'h8000; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 40 && res_n < 2; i++) begin
            accepting = in_ready && in_valid;
            if (out_valid && out_ready) begin
                res[res_n] = {sum, cout, ov};
                res_n++;
            end
            @(posedge clk); #1;
            if (accepting && acc_n < 2) begin
                acc_t[acc_n] = i;
                acc_n++;
                a = 16'h000F; b = 16'h0001;
                if (acc_n == 2) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_results", res_n, 32'd2);
        chk("b2b_accepts", acc_n, 32'd2);
        chk("b2b_spacing", acc_t[1] - acc_t[0], 32'd6);
        chk("b2b_first", {14'd0, res[0]}, {14'd0, 16'h0000, 1'b1, 1'b1});
        chk("b2b_second", {14'd0, res[1]}, {14'd0, 16'h0010, 1'b0, 1'b0});

        // Reset during the second RUN cycle
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_outputs", {14'd0, sum, cout, ov}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_idle", {31'd0, in_ready}, 32'd1);
        run_op(16'h0003, 16'h0004, 1'b0, 0, 1'b0, 16'h0007, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rcin = 1'($urandom);
            model(ra, rb, rcin, rs, rc, ro);
            run_op(ra, rb, rcin, int'($urandom_range(0, 2)), 1'($urandom), rs, rc, ro);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
